ofifo_aligned: RTL and testbench
================================

Name: ofifo_aligned

Overview:
Parametrised output FIFO bank that collects per-column results from the PE array and drains them as aligned full rows. There are COL independent column queues, each DEPTH deep and written at its own rate. A row is popped only when every column holds data. The block adds to the previous output FIFO:
- configurable depth
- occupancy reporting
- almost-full back-pressure
- sticky overflow/underflow error flags
- synchronous flush
- explicit output-valid strobe

Parameters:
COL, 8, number of columns (channels)
BW, 4, bits per column entry
DEPTH, 64, entries per column; power of two, >= 2
AF_LEVEL, 56, almost-full threshold in entries; 1..DEPTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of all queues and flags
wr  input  COL  per-column write strobe
in  input  BW*COL  write data; column i at [BW*(i+1)-1:BW*i]
rd  input  1  row pop request
out  output  BW*COL  registered popped row
out_valid  output  1  out holds a newly popped row (one-cycle strobe)
o_valid  output  1  every column non-empty (row available)
o_ready  output  1  no column full
o_full  output  1  any column full
o_almost_full  output  1  any column count >= AF_LEVEL
o_rows  output  $clog2(DEPTH)+1  complete rows available = min column count
o_overflow  output  1  sticky: a write was dropped
o_underflow  output  1  sticky: rd arrived while o_valid low

Behaviour:
- Reset (reset=0, async): all pointers, counts, out, out_valid, o_overflow and o_underflow go to 0. Combinational outputs then read: o_valid=0, o_ready=1, o_full=0, o_almost_full=0, o_rows=0.
- Storage: each column is a circular buffer with ADDR_W=$clog2(DEPTH) address bits.
  - Read and write pointers are ADDR_W+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo 2*DEPTH.
  - Count = wptr - rptr, width ADDR_W+1, range 0..DEPTH.
- Pop:
  - pop = rd & o_valid.
  - On pop, every column's rptr increments in the same cycle.
  - out <= the row at the old rptrs, registered.
  - out_valid=1 in the following cycle only.
  - Total latency from rd to out is 1 cycle.
  - Back-to-back pops sustain 1 row/cycle.
  - Without a pop, out holds its last value and out_valid=0.
- Write to column i: accepted when wr[i] & (!full[i] | pop).
  - A full column therefore accepts a write in the same cycle as a pop; its count stays at DEPTH.
  - Write + pop on a non-full column: both occur and the count is unchanged.
  - Write to an empty column never bypasses to out (no fall-through); the data is visible to pop the next cycle.
- Dropped write: wr[i] & full[i] & !pop drops the data, leaves state unchanged and sets o_overflow.
- Underflow: rd & !o_valid is ignored and sets o_underflow.
- Sticky flags: o_overflow and o_underflow clear only on reset or flush.
- flush (sync, priority over wr/rd in the same cycle):
  - Zeroes all pointers, out_valid and both sticky flags.
  - out keeps its value.
  - Writes in the flush cycle are discarded.
- Status outputs: o_full, o_ready, o_almost_full, o_valid and o_rows are combinational from the registered counts, with no dependence on same-cycle wr/rd.
  - o_rows is a min-reduction tree over the COL counts.
- Reset asserted mid-stream: immediate clear, no partial row emitted. After release, the first accepted write lands at address 0.

Decomposition:
- Package ofifo_pkg:
  - clog2 helper function
  - derived constants ADDR_W and CNT_W = ADDR_W+1
  - default parameter values
- Sub-module ofifo_col (one per column, generated COL times). It holds:
  - the memory array and rptr/wptr
  - full/empty/count outputs
  - write-accept logic with pop override
- Top level holds:
  - pop generation
  - the registered out/out_valid
  - the min tree
  - the sticky flags
  - the status reductions

Test Plan:
1. COL=4, BW=4, DEPTH=4. Write 0x1,0x2,0x3 to columns 0..3 on staggered cycles, then rd. Required: o_valid rises only after column 3's first write; out=0x1111 with out_valid one cycle after rd; o_rows steps 0->1->2->3.
2. Fill column 0 with 4 entries while the other columns are empty; then a 5th write. Required: o_full=1, o_ready=0, o_overflow=1, count stays 4, o_valid=0.
3. All columns full, and in one cycle rd plus wr to all columns with 0xA. Required: the write is accepted, counts stay 4, o_overflow=0; after 4 more pops the last out=0xAAAA.
4. Wrap test: 10 write/pop pairs with incrementing data. Required: out sequence 0..9 in order across pointer wrap; o_rows never exceeds 4.
5. rd on an empty bank. Required: out_valid=0, o_underflow=1. Then flush. Required: o_underflow=0, o_rows=0, and out unchanged.
6. Assert reset low asynchronously between clock edges with 2 rows queued. Required: o_valid=0, out=0 and out_valid=0 immediately; a later write/pop returns the new data only.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared constants and helpers for the aligned output FIFO bank.
package ofifo_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  localparam int unsigned DEF_COL      = 8;
  localparam int unsigned DEF_BW       = 4;
  localparam int unsigned DEF_DEPTH    = 64;
  localparam int unsigned DEF_AF_LEVEL = 56;
  localparam int unsigned DEF_ADDR_W   = clog2(DEF_DEPTH);
  localparam int unsigned DEF_CNT_W    = DEF_ADDR_W + 1;

endpackage

// File: rtl/ofifo_col.sv
// Single column queue: circular buffer with wrap-bit pointers; a write to a full
// column is still accepted when the row pop frees a slot in the same cycle.
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int unsigned BW    = DEF_BW,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr,
  input  logic [BW-1:0]          din,
  input  logic                   pop,
  output logic [BW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [BW-1:0]    mem [DEPTH];
  logic [CNT_W-1:0] wptr_q, rptr_q;
  logic             accept;

  assign count  = wptr_q - rptr_q;
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign accept = wr & (~full | pop) & ~flush;
  assign dout   = mem[rptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (accept) wptr_q <= wptr_q + 1'b1;
      if (pop)    rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage is not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr_q[ADDR_W-1:0]] <= din;
  end

endmodule

// File: rtl/ofifo_aligned.sv
// Output FIFO bank: COL independent column queues drained as aligned rows, with
// occupancy, almost-full, sticky error flags and synchronous flush.
module ofifo_aligned
  import ofifo_pkg::*;
#(
  parameter int unsigned COL      = DEF_COL,
  parameter int unsigned BW       = DEF_BW,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [COL-1:0]        wr,
  input  logic [BW*COL-1:0]     in,
  input  logic                  rd,
  output logic [BW*COL-1:0]     out,
  output logic                  out_valid,
  output logic                  o_valid,
  output logic                  o_ready,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [clog2(DEPTH):0] o_rows,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned NLEAF  = 1 << clog2(COL);

  logic [COL-1:0]       full, empty;
  logic [COL*CNT_W-1:0] cnts;
  logic [BW*COL-1:0]    row;
  logic                 pop, drop, af;

  logic [BW*COL-1:0] out_q;
  logic              out_valid_q, overflow_q, underflow_q;

  assign pop  = rd & o_valid & ~flush;
  assign drop = |(wr & full) & ~pop;

  for (genvar i = 0; i < COL; i++) begin : g_col
    ofifo_col #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .wr    (wr[i]),
      .din   (in[BW*i +: BW]),
      .pop   (pop),
      .dout  (row[BW*i +: BW]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (cnts[CNT_W*i +: CNT_W])
    );
  end

  // Balanced min tree; unused leaves are padded with all-ones, above any real count.
  function automatic logic [CNT_W-1:0] min_tree(input logic [COL*CNT_W-1:0] c);
    logic [NLEAF*CNT_W-1:0] padded;
    logic [CNT_W-1:0]       node [2*NLEAF-1];
    padded = '1;
    padded[COL*CNT_W-1:0] = c;
    for (int i = 0; i < int'(NLEAF); i++) begin
      node[int'(NLEAF) - 1 + i] = padded[CNT_W*i +: CNT_W];
    end
    for (int n = int'(NLEAF) - 2; n >= 0; n--) begin
      node[n] = (node[2*n+1] < node[2*n+2]) ? node[2*n+1] : node[2*n+2];
    end
    return node[0];
  endfunction

  always_comb begin
    af = 1'b0;
    for (int i = 0; i < int'(COL); i++) begin
      if (cnts[CNT_W*i +: CNT_W] >= CNT_W'(AF_LEVEL)) af = 1'b1;
    end
  end

  assign o_valid       = ~|empty;
  assign o_full        = |full;
  assign o_ready       = ~o_full;
  assign o_almost_full = af;
  assign o_rows        = min_tree(cnts);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_valid_q <= pop;
      if (pop)             out_q       <= row;
      if (drop)            overflow_q  <= 1'b1;
      if (rd && !o_valid)  underflow_q <= 1'b1;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_ofifo_aligned.sv
// Directed bench for ofifo_aligned with COL=4, BW=4, DEPTH=4, AF_LEVEL=3.
module tb_ofifo_aligned;

  localparam int unsigned COL = 4;
  localparam int unsigned BW  = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  wr = '0;
  logic [15:0] in = '0;
  logic        rd = 1'b0;
  logic [15:0] out;
  logic        out_valid, o_valid, o_ready, o_full, o_almost_full;
  logic [2:0]  o_rows;
  logic        o_overflow, o_underflow;

  int compared = 0;
  int mismatched = 0;

  ofifo_aligned #(
    .COL      (COL),
    .BW       (BW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .wr            (wr),
    .in            (in),
    .rd            (rd),
    .out           (out),
    .out_valid     (out_valid),
    .o_valid       (o_valid),
    .o_ready       (o_ready),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_rows        (o_rows),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rep(input logic [3:0] v);
    return {v, v, v, v};
  endfunction

  logic [15:0] exp3 [4];

  initial begin
    exp3 = '{16'h2222, 16'h3333, 16'h4444, 16'hAAAA};

    // Reset state
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_full", o_full, 0);
    chk("rst_af", o_almost_full, 0);
    chk("rst_rows", o_rows, 0);
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_unf", o_underflow, 0);
    @(posedge clk);
    #2 reset = 1'b1;

    // 1: staggered column writes of 1,2,3
    for (int k = 0; k < 6; k++) begin
      wr = '0;
      for (int c = 0; c < 4; c++) begin
        if (k - c >= 0 && k - c < 3) begin
          wr[c] = 1'b1;
          in[4*c +: 4] = 4'(k - c + 1);
        end
      end
      tick();
      chk("t1_valid", o_valid, k >= 3);
      chk("t1_rows", o_rows, (k >= 3) ? k - 2 : 0);
      chk("t1_af", o_almost_full, k >= 2);
    end
    wr = '0;
    chk("t1_full", o_full, 0);
    rd = 1'b1;
    tick();
    chk("t1_out0", out, 16'h1111);
    chk("t1_ov0", out_valid, 1);
    chk("t1_rows0", o_rows, 2);
    tick();
    chk("t1_out1", out, 16'h2222);
    chk("t1_rows1", o_rows, 1);
    tick();
    rd = 1'b0;
    chk("t1_out2", out, 16'h3333);
    chk("t1_rows2", o_rows, 0);
    chk("t1_valid_end", o_valid, 0);
    tick();
    chk("t1_ov_idle", out_valid, 0);
    chk("t1_out_hold", out, 16'h3333);

    // 2: overfill column 0
    wr = 4'b0001;
    in = 16'h0005;
    repeat (4) tick();
    chk("t2_full", o_full, 1);
    chk("t2_ready", o_ready, 0);
    chk("t2_ovf_pre", o_overflow, 0);
    chk("t2_valid", o_valid, 0);
    tick();
    chk("t2_ovf", o_overflow, 1);
    chk("t2_count", dut.g_col[0].u_col.count, 4);
    chk("t2_valid2", o_valid, 0);
    chk("t2_full2", o_full, 1);
    wr = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_flush_ovf", o_overflow, 0);
    chk("t2_flush_full", o_full, 0);
    chk("t2_flush_out", out, 16'h3333);
    chk("t2_flush_rows", o_rows, 0);

    // 3: write to full columns while popping
    for (int v = 1; v <= 4; v++) begin
      wr = 4'hF;
      in = rep(4'(v));
      tick();
    end
    chk("t3_full", o_full, 1);
    chk("t3_rows", o_rows, 4);
    chk("t3_af", o_almost_full, 1);
    rd = 1'b1;
    wr = 4'hF;
    in = 16'hAAAA;
    tick();
    wr = '0;
    chk("t3_out", out, 16'h1111);
    chk("t3_ov", out_valid, 1);
    chk("t3_rows_kept", o_rows, 4);
    chk("t3_ovf", o_overflow, 0);
    chk("t3_full_kept", o_full, 1);
    for (int p = 0; p < 4; p++) begin
      tick();
      chk("t3_drain", out, exp3[p]);
    end
    rd = 1'b0;
    chk("t3_rows_end", o_rows, 0);

    // 4: write/pop pairs across pointer wrap
    for (int d = 0; d < 10; d++) begin
      wr = 4'hF;
      in = rep(4'(d));
      tick();
      chk("t4_rows_w", o_rows, 1);
      wr = '0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("t4_out", out, rep(4'(d)));
      chk("t4_ov", out_valid, 1);
      chk("t4_rows_p", o_rows, 0);
    end

    // 5: underflow, then flush
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t5_ov", out_valid, 0);
    chk("t5_unf", o_underflow, 1);
    chk("t5_out", out, 16'h9999);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_unf_clr", o_underflow, 0);
    chk("t5_rows", o_rows, 0);
    chk("t5_out_kept", out, 16'h9999);

    // 6: asynchronous reset mid-stream with 2 rows queued
    for (int v = 6; v <= 8; v++) begin
      wr = 4'hF;
      in = rep(4'(v));
      tick();
    end
    wr = '0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t6_out_pre", out, 16'h6666);
    chk("t6_ov_pre", out_valid, 1);
    chk("t6_rows_pre", o_rows, 2);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", o_valid, 0);
    chk("t6_out", out, 0);
    chk("t6_ov", out_valid, 0);
    chk("t6_rows", o_rows, 0);
    #1 reset = 1'b1;
    wr = 4'hF;
    in = 16'hBBBB;
    tick();
    wr = '0;
    chk("t6_rows_new", o_rows, 1);
    chk("t6_wptr", dut.g_col[0].u_col.wptr_q, 1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t6_out_new", out, 16'hBBBB);
    chk("t6_ov_new", out_valid, 1);
    chk("t6_rows_end", o_rows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
